// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared constants for the AXI-Lite load/store unit: func3
//                codes, FSM state encoding, response codes, size masks.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // RISC-V load/store func3 codes (stores share B/H/W/D encodings)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Byte-enable patterns for an access at lane 0
  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_W    = 3'd3,
    S_B    = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Size field func3[1:0] -> byte-enable pattern
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return MASK_B;
      2'd1:    return MASK_H;
      2'd2:    return MASK_W;
      default: return MASK_D;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_axi_if.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_axi_if
//  Description : AXI4-Lite-style data-memory port of the load/store unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lsu_axi_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              m_arvalid;
  logic              m_arready;
  logic [ADDR_W-1:0] m_araddr;
  logic              m_rvalid;
  logic              m_rready;
  logic [XLEN-1:0]   m_rdata;
  logic [1:0]        m_rresp;
  logic              m_awvalid;
  logic              m_awready;
  logic [ADDR_W-1:0] m_awaddr;
  logic              m_wvalid;
  logic              m_wready;
  logic [XLEN-1:0]   m_wdata;
  logic [XLEN/8-1:0] m_wstrb;
  logic              m_bvalid;
  logic              m_bready;
  logic [1:0]        m_bresp;

  modport master (
    output m_arvalid, m_araddr, m_rready, m_awvalid, m_awaddr,
           m_wvalid, m_wdata, m_wstrb, m_bready,
    input  m_arready, m_rvalid, m_rdata, m_rresp, m_awready,
           m_wready, m_bvalid, m_bresp
  );

  modport slave (
    input  m_arvalid, m_araddr, m_rready, m_awvalid, m_awaddr,
           m_wvalid, m_wdata, m_wstrb, m_bready,
    output m_arready, m_rvalid, m_rdata, m_rresp, m_awready,
           m_wready, m_bvalid, m_bresp
  );
endinterface
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_lane_align
//  Description : Combinational byte-lane logic: load extract/extend, store
//                shift, write-strobe generation, misalign/illegal detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                   func3,
  input  logic [$clog2(XLEN/8)-1:0]    off,
  input  logic                         is_load,
  input  logic                         is_store,
  input  logic [XLEN-1:0]              wdata,
  input  logic [XLEN-1:0]              rdata,
  output logic [XLEN-1:0]              load_val,
  output logic [XLEN-1:0]              store_data,
  output logic [XLEN/8-1:0]            store_strb,
  output logic                         bad
);
  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  logic [OFF_W+2:0] bit_sh;
  logic [XLEN-1:0]  shifted;
  logic [XLEN-1:0]  left;
  logic [6:0]       nbits;
  logic [6:0]       ext_sh;
  logic [7:0]       m8;
  logic [2:0]       off3;
  logic [2:0]       amask;
  logic             legal;

  // Lane shifting and sign/zero extension; shifting the field to the top and
  // back down performs the extension without per-size replication terms.
  always_comb begin
    bit_sh  = {off, 3'b000};
    shifted = rdata >> bit_sh;
    case (func3[1:0])
      2'd0:    nbits = 7'd8;
      2'd1:    nbits = 7'd16;
      2'd2:    nbits = 7'd32;
      default: nbits = 7'd64;
    endcase
    if (nbits > 7'(XLEN)) nbits = 7'(XLEN);
    ext_sh = 7'(XLEN) - nbits;
    left   = shifted << ext_sh;
    if (func3[2]) load_val = left >> ext_sh;
    else          load_val = $unsigned($signed(left) >>> ext_sh);
    store_data = wdata << bit_sh;
    m8         = size_mask(func3[1:0]) << off;
    store_strb = m8[STRB_W-1:0];
  end

  // Legality of func3 for the current XLEN plus natural-alignment check
  always_comb begin
    legal = 1'b0;
    if (is_load && is_store) begin
      legal = 1'b0;
    end else if (is_load) begin
      case (func3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: legal = 1'b1;
        F3_D, F3_WU:                    legal = (XLEN == 64);
        default:                        legal = 1'b0;
      endcase
    end else if (is_store) begin
      case (func3)
        F3_B, F3_H, F3_W: legal = 1'b1;
        F3_D:             legal = (XLEN == 64);
        default:          legal = 1'b0;
      endcase
    end
    off3 = 3'(off);
    case (func3[1:0])
      2'd0:    amask = 3'b000;
      2'd1:    amask = 3'b001;
      2'd2:    amask = 3'b011;
      default: amask = 3'b111;
    endcase
    bad = (is_load || is_store) && (!legal || (|(off3 & amask)));
  end

endmodule
`default_nettype wire

// File: rtl/lsu_axi.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_axi
//  Description : Load/store unit between EXU and WBU, accessing data memory
//                over an AXI4-Lite-style master port with multi-cycle latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_axi
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int PKG_W  = 107
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pre_valid,
  output logic              o_pre_ready,
  output logic              o_post_valid,
  input  logic              i_post_ready,
  input  logic [PKG_W-1:0]  i_pkg,
  input  logic              i_is_load,
  input  logic              i_is_store,
  input  logic [2:0]        i_func3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [XLEN-1:0]   i_wdata,
  output logic [PKG_W-1:0]  o_pkg,
  output logic [XLEN-1:0]   o_rd,
  output logic              o_err,
  lsu_axi_if.master         axi
);
  localparam int OFF_W = $clog2(XLEN / 8);

  state_t              state, state_nx;
  logic [PKG_W-1:0]    pkg_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          func3_q;
  logic [XLEN-1:0]     wdata_q;
  logic [XLEN/8-1:0]   wstrb_q;
  logic [XLEN-1:0]     rd_q;
  logic                err_q;
  logic                aw_done;
  logic                w_done;
  logic                accept;
  logic [2:0]          f3_sel;
  logic [OFF_W-1:0]    off_sel;
  logic [XLEN-1:0]     ld_val;
  logic [XLEN-1:0]     st_data;
  logic [XLEN/8-1:0]   st_strb;
  logic                bad;

  assign accept  = i_pre_valid && (state == S_IDLE);
  // While idle the lane logic looks at the incoming request; afterwards it
  // works on the latched access so the read data can be aligned in R.
  assign f3_sel  = (state == S_IDLE) ? i_func3 : func3_q;
  assign off_sel = (state == S_IDLE) ? i_addr[OFF_W-1:0] : addr_q[OFF_W-1:0];

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .func3      (f3_sel),
    .off        (off_sel),
    .is_load    (i_is_load),
    .is_store   (i_is_store),
    .wdata      (i_wdata),
    .rdata      (axi.m_rdata),
    .load_val   (ld_val),
    .store_data (st_data),
    .store_strb (st_strb),
    .bad        (bad)
  );

  assign o_pkg        = pkg_q;
  assign o_rd         = rd_q;
  assign o_err        = err_q;
  assign axi.m_araddr = addr_q;
  assign axi.m_awaddr = addr_q;
  assign axi.m_wdata  = wdata_q;
  assign axi.m_wstrb  = wstrb_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nx      = state;
    o_pre_ready   = 1'b0;
    o_post_valid  = 1'b0;
    axi.m_arvalid = 1'b0;
    axi.m_rready  = 1'b0;
    axi.m_awvalid = 1'b0;
    axi.m_wvalid  = 1'b0;
    axi.m_bready  = 1'b0;
    case (state)
      S_IDLE: begin
        o_pre_ready = 1'b1;
        if (i_pre_valid) begin
          if (!(i_is_load || i_is_store) || bad) state_nx = S_DONE;
          else if (i_is_load)                    state_nx = S_AR;
          else                                   state_nx = S_W;
        end
      end
      S_AR: begin
        axi.m_arvalid = 1'b1;
        if (axi.m_arready) state_nx = S_R;
      end
      S_R: begin
        axi.m_rready = 1'b1;
        if (axi.m_rvalid) state_nx = S_DONE;
      end
      S_W: begin
        axi.m_awvalid = !aw_done;
        axi.m_wvalid  = !w_done;
        if ((aw_done || axi.m_awready) && (w_done || axi.m_wready)) state_nx = S_B;
      end
      S_B: begin
        axi.m_bready = 1'b1;
        if (axi.m_bvalid) state_nx = S_DONE;
      end
      S_DONE: begin
        o_post_valid = 1'b1;
        if (i_post_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Request latching, write-channel bookkeeping and result capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      pkg_q   <= '0;
      addr_q  <= '0;
      func3_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          pkg_q   <= i_pkg;
          addr_q  <= i_addr;
          func3_q <= i_func3;
          wdata_q <= st_data;
          wstrb_q <= st_strb;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          err_q   <= 1'b0;
          rd_q    <= XLEN'(i_addr);
          if (i_is_load || i_is_store) begin
            if (bad) begin
              err_q <= 1'b1;
              rd_q  <= '0;
            end else if (i_is_load) begin
              rd_q  <= '0;
            end
          end
        end
        S_W: begin
          if (axi.m_awready) aw_done <= 1'b1;
          if (axi.m_wready)  w_done  <= 1'b1;
        end
        S_R: if (axi.m_rvalid) begin
          if (axi.m_rresp != RESP_OKAY) begin
            err_q <= 1'b1;
            rd_q  <= '0;
          end else begin
            rd_q  <= ld_val;
          end
        end
        S_B: if (axi.m_bvalid && (axi.m_bresp != RESP_OKAY)) err_q <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_axi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_axi
//  Description : Self-checking bench for lsu_axi (XLEN=32) with a reactive
//                AXI-Lite slave and a byte-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_axi;
  import lsu_pkg::*;

  localparam int XLEN = 32, ADDR_W = 32, PKG_W = 107;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             i_pre_valid, o_pre_ready, o_post_valid, i_post_ready;
  logic [PKG_W-1:0] i_pkg, o_pkg;
  logic             i_is_load, i_is_store, o_err;
  logic [2:0]       i_func3;
  logic [31:0]      i_addr, i_wdata, o_rd;

  lsu_axi_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) axi ();

  lsu_axi #(.XLEN(XLEN), .ADDR_W(ADDR_W), .PKG_W(PKG_W)) dut (
    .clk(clk), .rst(rst),
    .i_pre_valid(i_pre_valid), .o_pre_ready(o_pre_ready),
    .o_post_valid(o_post_valid), .i_post_ready(i_post_ready),
    .i_pkg(i_pkg), .i_is_load(i_is_load), .i_is_store(i_is_store),
    .i_func3(i_func3), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_pkg(o_pkg), .o_rd(o_rd), .o_err(o_err), .axi(axi)
  );

  int n_cmp = 0, n_fail = 0;

  // Observations of the last transaction
  int               r_cycles, r_unstable;
  logic [31:0]      r_rd, r_araddr, r_awaddr, r_wdata;
  logic [3:0]       r_wstrb;
  logic             r_err, r_saw_ar, r_saw_aw, r_saw_w, r_aw_first;
  logic             r_timeout, r_pkg_ok, r_released, r_pre_issue;
  logic [PKG_W-1:0] exp_pkg;

  // ---------------- reference model (byte view of the bus word) ----------
  function automatic logic model_bad(input logic ld, input logic st,
                                     input logic [2:0] f3, input logic [31:0] a);
    int sz;
    if (!ld && !st) return 1'b0;
    if (ld && st) return 1'b1;
    if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    if (st && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b1;
    sz = 1 << f3[1:0];
    return (int'(a % 32'(sz)) != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3,
                                             input logic [31:0] a, input logic [31:0] d);
    int sz, off;
    longint unsigned v;
    sz = 1 << f3[1:0];
    off = int'(a[1:0]);
    v = 0;
    for (int i = 0; i < sz; i++)
      v = v | (longint'((d >> (8 * (off + i))) & 32'hFF) << (8 * i));
    if (!f3[2] && v[8*sz-1]) v = v | (~64'd0 << (8 * sz));
    return v[31:0];
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, output logic [31:0] wdo,
                             output logic [3:0] strb);
    int sz, off;
    sz = 1 << f3[1:0];
    off = int'(a[1:0]);
    wdo = '0;
    strb = '0;
    for (int i = 0; i < sz; i++) begin
      wdo[8*(off+i)+:8] = wd[8*i+:8];
      strb[off+i] = 1'b1;
    end
  endtask

  // ---------------- driver + reactive slave --------------------------------
  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdat, input logic [1:0] rresp,
                        input logic [1:0] bresp, input int arw, input int rw,
                        input int aww, input int ww, input int bw, input int hold);
    int arc, rc, awc, wc, bc, cyc;
    logic [PKG_W-1:0] pk;
    arc = 0; rc = 0; awc = 0; wc = 0; bc = 0;
    r_saw_ar = 0; r_saw_aw = 0; r_saw_w = 0; r_aw_first = 0; r_timeout = 0;
    r_araddr = 'x; r_awaddr = 'x; r_wdata = 'x; r_wstrb = 'x; r_unstable = 0;
    pk = PKG_W'({$urandom(), $urandom(), $urandom(), $urandom()});
    @(negedge clk);
    r_pre_issue = o_pre_ready;
    i_pre_valid = 1'b1; i_is_load = ld; i_is_store = st; i_func3 = f3;
    i_addr = a; i_wdata = wd; i_pkg = pk; exp_pkg = pk;
    @(negedge clk);
    i_pre_valid = 1'b0; i_is_load = 1'b0; i_is_store = 1'b0;
    i_func3 = 3'($urandom()); i_addr = $urandom(); i_wdata = $urandom();
    i_pkg = PKG_W'({$urandom(), $urandom(), $urandom(), $urandom()});
    cyc = 1;
    while (1) begin
      if (axi.m_arvalid) begin r_saw_ar = 1; r_araddr = axi.m_araddr; end
      if (axi.m_awvalid) begin r_saw_aw = 1; r_awaddr = axi.m_awaddr; end
      if (axi.m_wvalid)  begin r_saw_w = 1; r_wdata = axi.m_wdata; r_wstrb = axi.m_wstrb; end
      if (!axi.m_awvalid && axi.m_wvalid) r_aw_first = 1;
      if (o_post_valid) break;
      if (cyc > 100) begin r_timeout = 1; break; end
      axi.m_arready = axi.m_arvalid && (arc == arw);
      if (axi.m_arvalid) arc++;
      axi.m_awready = axi.m_awvalid && (awc == aww);
      if (axi.m_awvalid) awc++;
      axi.m_wready = axi.m_wvalid && (wc == ww);
      if (axi.m_wvalid) wc++;
      axi.m_rvalid = axi.m_rready && (rc == rw);
      axi.m_rdata = axi.m_rvalid ? rdat : $urandom();
      axi.m_rresp = axi.m_rvalid ? rresp : 2'b00;
      if (axi.m_rready) rc++;
      axi.m_bvalid = axi.m_bready && (bc == bw);
      axi.m_bresp = axi.m_bvalid ? bresp : 2'b00;
      if (axi.m_bready) bc++;
      @(negedge clk);
      cyc++;
    end
    axi.m_arready = 0; axi.m_rvalid = 0; axi.m_awready = 0; axi.m_wready = 0;
    axi.m_bvalid = 0; axi.m_rresp = 0; axi.m_bresp = 0;
    r_cycles = cyc; r_rd = o_rd; r_err = o_err; r_pkg_ok = (o_pkg === exp_pkg);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (o_post_valid !== 1'b1 || o_pre_ready !== 1'b0 || o_rd !== r_rd ||
          o_err !== r_err || o_pkg !== exp_pkg) r_unstable++;
    end
    i_post_ready = 1'b1;
    @(negedge clk);
    r_released = (o_post_valid === 1'b0) && (o_pre_ready === 1'b1);
    i_post_ready = 1'b0;
  endtask

  // ---------------- tests ---------------------------------------------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({axi.m_arvalid, axi.m_rready, axi.m_awvalid, axi.m_wvalid, axi.m_bready, o_post_valid} !== 6'b0) begin
      n_fail++; $display("FAIL reset_valids: got %b want 000000", {axi.m_arvalid, axi.m_rready, axi.m_awvalid, axi.m_wvalid, axi.m_bready, o_post_valid}); end
    n_cmp++; if (o_rd !== 32'h0 || o_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_rd_err: got rd=%h err=%b want 0/0", o_rd, o_err); end
    n_cmp++; if (o_pkg !== '0) begin
      n_fail++; $display("FAIL reset_pkg: got %h want 0", o_pkg); end
    n_cmp++; if ({axi.m_araddr, axi.m_awaddr, axi.m_wdata, axi.m_wstrb} !== '0) begin
      n_fail++; $display("FAIL reset_bus: got ar=%h aw=%h wd=%h st=%h want 0", axi.m_araddr, axi.m_awaddr, axi.m_wdata, axi.m_wstrb); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (o_pre_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_ready: got %b want 1", o_pre_ready); end
  endtask

  task automatic test_alu();
    run_op(0, 0, 3'($urandom()), 32'h1234, $urandom(), 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (r_cycles !== 1) begin n_fail++; $display("FAIL alu_latency: got %0d want 1", r_cycles); end
    n_cmp++; if (r_rd !== 32'h1234 || r_err !== 0) begin n_fail++; $display("FAIL alu_rd: got %h err=%b want 00001234 err=0", r_rd, r_err); end
    n_cmp++; if ({r_saw_ar, r_saw_aw, r_saw_w} !== 3'b000) begin n_fail++; $display("FAIL alu_nobus: got %b want 000", {r_saw_ar, r_saw_aw, r_saw_w}); end
    n_cmp++; if (r_pkg_ok !== 1'b1 || r_released !== 1'b1 || r_pre_issue !== 1'b1) begin
      n_fail++; $display("FAIL alu_pkg_release: got pkg_ok=%b rel=%b pre=%b want 1/1/1", r_pkg_ok, r_released, r_pre_issue); end
  endtask

  task automatic test_lb();
    logic [31:0] d;
    d = {8'h80, 24'($urandom())};
    run_op(1, 0, F3_B, 32'h8000_0003, 0, d, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (r_araddr !== 32'h8000_0003) begin n_fail++; $display("FAIL lb_araddr: got %h want 80000003", r_araddr); end
    n_cmp++; if (r_rd !== 32'hFFFF_FF80 || r_err !== 0) begin n_fail++; $display("FAIL lb_rd: got %h err=%b want ffffff80 err=0", r_rd, r_err); end
    n_cmp++; if (r_cycles !== 3) begin n_fail++; $display("FAIL lb_latency: got %0d want 3", r_cycles); end
  endtask

  task automatic test_sh();
    run_op(0, 1, F3_H, 32'h102, 32'h5555_ABCD, 0, 0, 0, 0, 0, 0, 2, 0, 0);
    n_cmp++; if (r_wdata !== 32'hABCD_0000 || r_wstrb !== 4'hC) begin
      n_fail++; $display("FAIL sh_wdata: got %h/%h want abcd0000/c", r_wdata, r_wstrb); end
    n_cmp++; if (r_aw_first !== 1'b1 || r_awaddr !== 32'h102) begin
      n_fail++; $display("FAIL sh_aw: got first=%b addr=%h want 1/00000102", r_aw_first, r_awaddr); end
    n_cmp++; if (r_cycles !== 5 || r_rd !== 32'h102 || r_err !== 0) begin
      n_fail++; $display("FAIL sh_done: got cyc=%0d rd=%h err=%b want 5/00000102/0", r_cycles, r_rd, r_err); end
  endtask

  task automatic test_misalign();
    run_op(1, 0, F3_W, 32'h101, 0, $urandom(), 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (r_err !== 1 || r_rd !== 0 || r_saw_ar !== 0 || r_cycles !== 1) begin
      n_fail++; $display("FAIL lw_misalign: got err=%b rd=%h ar=%b cyc=%0d want 1/0/0/1", r_err, r_rd, r_saw_ar, r_cycles); end
    run_op(1, 0, F3_D, 32'h200, 0, $urandom(), 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (r_err !== 1 || r_saw_ar !== 0) begin
      n_fail++; $display("FAIL ld_illegal32: got err=%b ar=%b want 1/0", r_err, r_saw_ar); end
  endtask

  task automatic test_rresp_hold();
    run_op(1, 0, F3_W, 32'h400, 0, $urandom(), 2'b10, 0, 0, 0, 0, 0, 0, 3);
    n_cmp++; if (r_err !== 1 || r_rd !== 0 || r_cycles !== 3) begin
      n_fail++; $display("FAIL lw_rresp: got err=%b rd=%h cyc=%0d want 1/0/3", r_err, r_rd, r_cycles); end
    n_cmp++; if (r_unstable !== 0 || r_released !== 1) begin
      n_fail++; $display("FAIL lw_hold: got unstable=%0d rel=%b want 0/1", r_unstable, r_released); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    i_pre_valid = 1; i_is_load = 1; i_is_store = 0; i_func3 = F3_W; i_addr = 32'h40;
    @(negedge clk);
    i_pre_valid = 0; i_is_load = 0;
    axi.m_arready = 1;
    @(negedge clk);
    axi.m_arready = 0;
    n_cmp++; if (axi.m_rready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_r: got rready=%b want 1", axi.m_rready); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if ({axi.m_arvalid, axi.m_rready, axi.m_awvalid, axi.m_wvalid, axi.m_bready, o_post_valid} !== 6'b0 || o_rd !== 0) begin
      n_fail++; $display("FAIL rstmid_valids: got %b rd=%h want 000000 rd=0", {axi.m_arvalid, axi.m_rready, axi.m_awvalid, axi.m_wvalid, axi.m_bready, o_post_valid}, o_rd); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (o_pre_ready !== 1'b1 || o_post_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_idle: got pre=%b post=%b want 1/0", o_pre_ready, o_post_valid); end
    run_op(0, 0, 0, 32'hCAFE_0001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (r_rd !== 32'hCAFE_0001 || r_cycles !== 1) begin
      n_fail++; $display("FAIL rstmid_recover: got rd=%h cyc=%0d want cafe0001/1", r_rd, r_cycles); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      logic ld, st, bad;
      logic [2:0] f3;
      logic [31:0] a, wd, d, ew, erd;
      logic [3:0] es;
      logic [1:0] rr, br;
      int arw, rw, aww, ww, bw, hold, sel, ecyc;
      logic eerr;
      logic [2:0] ebus;
      sel = $urandom_range(0, 9);
      ld = (sel >= 2 && sel <= 5) || sel == 9;
      st = (sel >= 6) ;
      f3 = 3'($urandom());
      a = $urandom();
      if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
      wd = $urandom(); d = $urandom();
      rr = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      br = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      arw = $urandom_range(0, 2); rw = $urandom_range(0, 2);
      aww = $urandom_range(0, 2); ww = $urandom_range(0, 2); bw = $urandom_range(0, 2);
      hold = $urandom_range(0, 2);
      bad = model_bad(ld, st, f3, a);
      ew = 'x; es = 'x;
      if (!ld && !st) begin ecyc = 1; erd = a; eerr = 0; ebus = 3'b000; end
      else if (bad) begin ecyc = 1; erd = 0; eerr = 1; ebus = 3'b000; end
      else if (ld) begin
        ecyc = 3 + arw + rw; eerr = (rr != 0); erd = eerr ? 32'h0 : model_load(f3, a, d); ebus = 3'b100;
      end else begin
        ecyc = 3 + ((aww > ww) ? aww : ww) + bw; eerr = (br != 0); erd = a; ebus = 3'b011;
        model_store(f3, a, wd, ew, es);
      end
      run_op(ld, st, f3, a, wd, d, rr, br, arw, rw, aww, ww, bw, hold);
      n_cmp++; if (r_timeout !== 0 || r_cycles !== ecyc) begin
        n_fail++; $display("FAIL rnd%0d_latency: got %0d (to=%b) want %0d", it, r_cycles, r_timeout, ecyc); end
      n_cmp++; if (r_rd !== erd || r_err !== eerr) begin
        n_fail++; $display("FAIL rnd%0d_result: ld=%b st=%b f3=%0d a=%h got rd=%h err=%b want rd=%h err=%b", it, ld, st, f3, a, r_rd, r_err, erd, eerr); end
      n_cmp++; if ({r_saw_ar, r_saw_aw, r_saw_w} !== ebus || r_pkg_ok !== 1 || r_unstable !== 0 || r_released !== 1) begin
        n_fail++; $display("FAIL rnd%0d_bus: got bus=%b pkg=%b unst=%0d rel=%b want %b/1/0/1", it, {r_saw_ar, r_saw_aw, r_saw_w}, r_pkg_ok, r_unstable, r_released, ebus); end
      if (ebus == 3'b100) begin
        n_cmp++; if (r_araddr !== a) begin n_fail++; $display("FAIL rnd%0d_araddr: got %h want %h", it, r_araddr, a); end
      end
      if (ebus == 3'b011) begin
        n_cmp++; if (r_awaddr !== a || r_wdata !== ew || r_wstrb !== es) begin
          n_fail++; $display("FAIL rnd%0d_wr: got %h/%h/%h want %h/%h/%h", it, r_awaddr, r_wdata, r_wstrb, a, ew, es); end
      end
    end
  endtask

  initial begin
    i_pre_valid = 0; i_post_ready = 0; i_pkg = '0; i_is_load = 0; i_is_store = 0;
    i_func3 = 0; i_addr = 0; i_wdata = 0;
    axi.m_arready = 0; axi.m_rvalid = 0; axi.m_rdata = 0; axi.m_rresp = 0;
    axi.m_awready = 0; axi.m_wready = 0; axi.m_bvalid = 0; axi.m_bresp = 0;
    test_reset();
    test_alu();
    test_lb();
    test_sh();
    test_misalign();
    test_rresp_hold();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_axi.md
Name: lsu_axi

Overview:
Parametrised successor to the single-cycle DPI load/store unit. It sits between EXU and WBU with the same valid/ready handshakes on both sides, but performs data-memory accesses through an AXI4-Lite-style master port with multi-cycle latency. It adds XLEN 32/64 support, byte-lane alignment, misalignment and bus-error detection, and an opaque passthrough payload.

Parameters:
XLEN, 32, data width; legal values 32 or 64; 64 enables LD/LWU/SD.
ADDR_W, 32, bus address width.
PKG_W, 107, width of the passthrough payload (imm, pc, rs1, jal/jalr/brch, rd_id, gpr_wen).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
i_pre_valid  in  1  EXU data valid
o_pre_ready  out  1  LSU can accept
o_post_valid  out  1  result register valid to WBU
i_post_ready  in  1  WBU accepts
i_pkg  in  PKG_W  passthrough payload
i_is_load  in  1  load request
i_is_store  in  1  store request
i_func3  in  3  access size/sign
i_addr  in  ADDR_W  ALU result: address, or writeback value for non-memory ops
i_wdata  in  XLEN  rs2 store data
o_pkg  out  PKG_W  registered payload
o_rd  out  XLEN  writeback value
o_err  out  1  misaligned, illegal func3, or bus error
m_arvalid/m_arready  out/in  1  read address handshake; m_araddr  out  ADDR_W
m_rvalid/m_rready  in/out  1  read data handshake; m_rdata  in  XLEN; m_rresp  in  2
m_awvalid/m_awready  out/in  1  write address handshake; m_awaddr  out  ADDR_W
m_wvalid/m_wready  out/in  1  write data handshake; m_wdata  out  XLEN; m_wstrb  out  XLEN/8
m_bvalid/m_bready  in/out  1  write response handshake; m_bresp  in  2

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE. All outputs 0: o_post_valid, every m_*valid/m_*ready, o_rd, o_pkg, o_err, addresses, wdata, wstrb. Reset mid-transaction abandons the transaction; its valids are 0 after that edge.
- o_pre_ready = (state==IDLE). An input is accepted when i_pre_valid & o_pre_ready; on acceptance all inputs are latched.
- FSM states: IDLE, AR, R, W (AW and W in flight), B, DONE.
- Transitions from IDLE on accept:
  - neither load nor store -> DONE, o_rd=i_addr truncated/zero-extended to XLEN.
  - misaligned or illegal func3 -> DONE, o_err=1, o_rd=0, no bus activity.
  - load -> AR.
  - store -> W.
- AR: m_arvalid=1 with stable m_araddr (the full, unaligned address) until m_arready -> R.
- R: m_rready=1 until m_rvalid. Lane offset = addr[log2(XLEN/8)-1:0]. The addressed bytes are extracted, then sign- or zero-extended per func3. rresp!=0 -> o_err=1, o_rd=0. -> DONE.
- W: m_awvalid and m_wvalid asserted together. Each deasserts independently on its own ready. m_wdata = wdata << 8*offset. m_wstrb = size mask (1/3/F/FF) << offset. When both have handshaken (the same cycle is allowed) -> B.
- B: m_bready=1 until m_bvalid. bresp!=0 -> o_err=1. -> DONE. o_rd for stores = latched i_addr.
- DONE: o_post_valid=1. o_rd/o_pkg/o_err stay stable until i_post_ready -> IDLE. No new accept is possible in DONE.
- Alignment: halfword needs addr[0]=0; word needs addr[1:0]=0; doubleword needs addr[2:0]=0.
- Legal func3 per XLEN:
  - XLEN=32: LB/LH/LW/LBU/LHU, SB/SH/SW.
  - XLEN=64: additionally LD(011), LWU(110), SD(011).
- is_load & is_store both 1 -> illegal, o_err=1.
- Latency, assuming zero-wait slave:
  - non-memory op: accept at N, o_post_valid at N+1.
  - load: post_valid at N+3.
  - store: post_valid at N+3.
- Each additional slave wait cycle adds one cycle.

Decomposition:
- Package lsu_pkg holds:
  - func3 localparams
  - FSM state encoding
  - RESP_OKAY=2'b00
  - size-mask constants
- Sub-module lsu_lane_align (combinational) performs load extract/extend, store shift, wstrb generation, and the misalign/illegal check.
- The FSM and payload registers live in lsu_axi.

Test Plan:
- ALU op, i_addr=0x1234, i_post_ready=1 -> o_post_valid one cycle after accept; o_rd=0x1234; no m_*valid seen.
- LB at 0x8000_0003, rdata=0x80xx_xxxx, ready=1 -> m_araddr=0x8000_0003; o_rd=0xFFFF_FF80; post_valid at N+3.
- SH at 0x102, wdata=0xABCD, awready 2 cycles before wready -> m_wdata=0xABCD_0000, m_wstrb=0xC; awvalid drops first; B then DONE.
- LW at 0x101 -> o_err=1, o_rd=0, no arvalid; post_valid at N+1.
- LW with rresp=2'b10, then i_post_ready held 0 for 3 cycles -> o_err=1; outputs stable, o_pre_ready=0 until release.
- rst=0 asserted while in R -> next cycle all valids/ready 0, state IDLE, o_pre_ready=1 after release.
